apb2axi_cpl_queue: RTL and testbench
====================================

APB2AXI_CPL_QUEUE -- requirements
Module: apb2axi_cpl_queue

Interface
REQ-001 SHALL have parameter CQ_DEPTH, default 4, FIFO entry count; power of two, >= 2.
REQ-002 SHALL have port pclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port presetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rd_cq_vld  input  1  read-response handler offers a completion.
REQ-005 SHALL have port rd_cq_entry  input  completion_entry_t  read completion (tag, resp, num_beats, error, err_beat_idx).
REQ-006 SHALL have port rd_cq_rdy  output  1  read completion accepted this cycle when high with rd_cq_vld.
REQ-007 SHALL have ports wr_cq_vld, wr_cq_entry, wr_cq_rdy  in/in/out  1/completion_entry_t/1  write-response handler equivalents.
REQ-008 SHALL have port cq_dir_cpl_vld  output  1  head entry valid toward directory.
REQ-009 SHALL have port cq_dir_cpl_entry  output  completion_entry_t  head entry.
REQ-010 SHALL have port cq_dir_cpl_rdy  input  1  directory accepts head.
REQ-011 SHALL have port cq_count  output  CQ_PTR_W+1  current occupancy.

Function
REQ-012 Storage SHALL be a CQ_DEPTH-entry circular buffer with wr_ptr, rd_ptr (CQ_PTR_W bits, natural wrap CQ_DEPTH-1 -> 0) and a separate occupancy counter.
REQ-013 full = (count == CQ_DEPTH); empty = (count == 0).
REQ-014 At most one push per cycle; push = (rd_cq_vld & rd_cq_rdy) | (wr_cq_vld & wr_cq_rdy).
REQ-015 rd_cq_rdy = !full & grant_rd; wr_cq_rdy = !full & grant_wr; rdy depends combinationally on vld (no other comb path input->output).
REQ-016 Arbitration: only one source valid -> it is granted; both valid -> source not granted last time wins (round-robin via 1-bit last_grant, updated only on an actual push).
REQ-017 When full, neither rdy asserts, even if a pop occurs the same cycle (no full-bypass).
REQ-018 cq_dir_cpl_vld = !empty; cq_dir_cpl_entry = mem[rd_ptr] driven from registers; pop = cq_dir_cpl_vld & cq_dir_cpl_rdy.
REQ-019 Latency: entry pushed at edge N is visible on cq_dir_cpl_* after edge N (next cycle); no empty-bypass.
REQ-020 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-021 Entry order at output SHALL equal push order; entry contents passed unmodified.
REQ-022 cq_dir_cpl_entry SHALL hold stable while vld high and rdy low.
REQ-023 Holding input entry while vld high and rdy low is the source's obligation; the block samples only on push.
REQ-024 cq_count SHALL equal count register (registered, 0..CQ_DEPTH).

Reset
REQ-025 presetn low SHALL immediately clear wr_ptr, rd_ptr, count to 0, last_grant to WR (so RD wins the first tie), all mem entries to '0.
REQ-026 During reset: cq_dir_cpl_vld=0, rd_cq_rdy=0, wr_cq_rdy=0, cq_count=0, cq_dir_cpl_entry='0.
REQ-027 Reset mid-operation SHALL discard all queued completions; first push after deassertion is accepted on the first rising edge with presetn high.

Structure
REQ-028 completion_entry_t, TAG_W and CQ_DEPTH default SHALL live in apb2axi_pkg; CQ_PTR_W = $clog2(CQ_DEPTH) derived locally.
REQ-029 Round-robin 2:1 arbiter is natural as sub-module apb2axi_rr_arb2 (inputs req[1:0], push; outputs gnt[1:0]); storage stays inline.
REQ-030 Implementation SHALL be synthesizable, no latches, single always_ff with asynchronous reset for all state.

Verification
REQ-031 Single read: rd_cq_vld=1 tag=3 resp=0 num_beats=4 for one cycle, cq_dir_cpl_rdy=1 -> vld high next cycle with tag=3, num_beats=4, then count returns 0.
REQ-032 Contention: rd and wr both valid for 4 cycles after reset, tags 1,2 (rd) and 5,6 (wr) -> output order 1,5,2,6.
REQ-033 Fill: cq_dir_cpl_rdy=0, push tags 0..4 from rd -> tags 0..3 accepted, count=4, rd_cq_rdy=0 for tag 4 until one pop; then tag 4 accepted the cycle after the pop.
REQ-034 Wrap: 10 pushes with continuous pop at rdy=1, depth 4 -> all 10 tags out in order, pointers wrap twice, count never exceeds 1.
REQ-035 Backpressure hold: head tag=7 error=1 err_beat_idx=2, rdy low 5 cycles -> entry stable all 5 cycles, popped on rdy.
REQ-036 Reset mid-stream: count=3, presetn low one cycle -> vld=0, count=0 immediately; next push tag=9 appears alone at output.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge: completion entries and source identifiers.
package apb2axi_pkg;

    localparam int TAG_W        = 4;
    localparam int BEAT_W       = 8;
    localparam int CQ_DEPTH_DEF = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [1:0]        resp;
        logic [BEAT_W-1:0] num_beats;
        logic              error;
        logic [BEAT_W-1:0] err_beat_idx;
    } completion_entry_t;

    typedef enum logic {
        SRC_RD = 1'b0,
        SRC_WR = 1'b1
    } cq_src_e;

endpackage

// File: rtl/apb2axi_rr_arb2.sv
// Two-requester round-robin arbiter; the grant history only moves on an accepted push.
module apb2axi_rr_arb2
    import apb2axi_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] req,
    input  logic       push,
    output logic [1:0] gnt
);

    cq_src_e last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == SRC_WR) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset history to WR so the read side wins the first tie.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant <= SRC_WR;
        end else if (push) begin
            last_grant <= gnt[1] ? SRC_WR : SRC_RD;
        end
    end

endmodule

// File: rtl/apb2axi_cpl_queue.sv
// Completion queue merging read and write response handlers into one ordered stream toward the directory.
module apb2axi_cpl_queue
    import apb2axi_pkg::*;
#(
    parameter  int CQ_DEPTH = CQ_DEPTH_DEF,
    localparam int CQ_PTR_W = $clog2(CQ_DEPTH)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              rd_cq_vld,
    input  completion_entry_t rd_cq_entry,
    output logic              rd_cq_rdy,
    input  logic              wr_cq_vld,
    input  completion_entry_t wr_cq_entry,
    output logic              wr_cq_rdy,
    output logic              cq_dir_cpl_vld,
    output completion_entry_t cq_dir_cpl_entry,
    input  logic              cq_dir_cpl_rdy,
    output logic [CQ_PTR_W:0] cq_count
);

    completion_entry_t   mem [CQ_DEPTH];
    logic [CQ_PTR_W-1:0] wr_ptr;
    logic [CQ_PTR_W-1:0] rd_ptr;
    logic [CQ_PTR_W:0]   count;

    logic              full;
    logic              empty;
    logic [1:0]        gnt;
    logic              push_rd;
    logic              push_wr;
    logic              push;
    logic              pop;
    completion_entry_t push_entry;

    assign full  = (count == (CQ_PTR_W+1)'(CQ_DEPTH));
    assign empty = (count == '0);

    apb2axi_rr_arb2 u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     ({wr_cq_vld, rd_cq_vld}),
        .push    (push),
        .gnt     (gnt)
    );

    // Ready is held low while in reset; full blocks both sources even when a pop is pending.
    assign rd_cq_rdy = presetn & ~full & gnt[0];
    assign wr_cq_rdy = presetn & ~full & gnt[1];

    assign push_rd    = rd_cq_vld & rd_cq_rdy;
    assign push_wr    = wr_cq_vld & wr_cq_rdy;
    assign push       = push_rd | push_wr;
    assign push_entry = push_wr ? wr_cq_entry : rd_cq_entry;

    assign cq_dir_cpl_vld   = ~empty;
    assign cq_dir_cpl_entry = mem[rd_ptr];
    assign pop              = cq_dir_cpl_vld & cq_dir_cpl_rdy;
    assign cq_count         = count;

    // Pointers rely on natural binary wrap, so CQ_DEPTH must be a power of two.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CQ_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi_cpl_queue.sv
// Directed bench for the completion queue with a scoreboard of expected output entries.
module tb_apb2axi_cpl_queue;
    import apb2axi_pkg::*;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              rd_cq_vld;
    completion_entry_t rd_cq_entry;
    logic              rd_cq_rdy;
    logic              wr_cq_vld;
    completion_entry_t wr_cq_entry;
    logic              wr_cq_rdy;
    logic              cq_dir_cpl_vld;
    completion_entry_t cq_dir_cpl_entry;
    logic              cq_dir_cpl_rdy;
    logic [2:0]        cq_count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    completion_entry_t sb[$];

    apb2axi_cpl_queue #(.CQ_DEPTH(4)) dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .rd_cq_vld        (rd_cq_vld),
        .rd_cq_entry      (rd_cq_entry),
        .rd_cq_rdy        (rd_cq_rdy),
        .wr_cq_vld        (wr_cq_vld),
        .wr_cq_entry      (wr_cq_entry),
        .wr_cq_rdy        (wr_cq_rdy),
        .cq_dir_cpl_vld   (cq_dir_cpl_vld),
        .cq_dir_cpl_entry (cq_dir_cpl_entry),
        .cq_dir_cpl_rdy   (cq_dir_cpl_rdy),
        .cq_count         (cq_count)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic completion_entry_t mk(input int tag, input int nb = 1,
                                             input int err = 0, input int idx = 0);
        completion_entry_t e;
        e.tag          = TAG_W'(tag);
        e.resp         = (err != 0) ? 2'b10 : 2'b00;
        e.num_beats    = BEAT_W'(nb);
        e.error        = (err != 0);
        e.err_beat_idx = BEAT_W'(idx);
        return e;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Output monitor: every handshake must match the oldest expected entry.
    always @(negedge pclk) begin
        if (presetn && cq_dir_cpl_vld && cq_dir_cpl_rdy) begin
            pops++;
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                completion_entry_t exp_e;
                exp_e = sb.pop_front();
                chk("pop_entry", 32'(cq_dir_cpl_entry), 32'(exp_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ri;
        int wi;
        int rtags [2];
        int wtags [2];
        int wins  [4];
        completion_entry_t e5;

        rtags = '{1, 2};
        wtags = '{5, 6};
        wins  = '{0, 1, 0, 1};

        rd_cq_vld      = 1'b1;
        wr_cq_vld      = 1'b1;
        rd_cq_entry    = mk(1);
        wr_cq_entry    = mk(2);
        cq_dir_cpl_rdy = 1'b1;

        repeat (2) @(negedge pclk);
        chk("rst_vld",    32'(cq_dir_cpl_vld),   32'd0);
        chk("rst_rd_rdy", 32'(rd_cq_rdy),        32'd0);
        chk("rst_wr_rdy", 32'(wr_cq_rdy),        32'd0);
        chk("rst_count",  32'(cq_count),         32'd0);
        chk("rst_entry",  32'(cq_dir_cpl_entry), 32'd0);
        tick();
        rd_cq_vld = 1'b0;
        wr_cq_vld = 1'b0;
        presetn   = 1'b1;

        // Single read completion
        tick();
        rd_cq_vld   = 1'b1;
        rd_cq_entry = mk(3, 4);
        @(negedge pclk);
        chk("t1_rd_rdy", 32'(rd_cq_rdy), 32'd1);
        sb.push_back(rd_cq_entry);
        tick();
        rd_cq_vld = 1'b0;
        @(negedge pclk);
        chk("t1_vld",   32'(cq_dir_cpl_vld),             32'd1);
        chk("t1_tag",   32'(cq_dir_cpl_entry.tag),       32'd3);
        chk("t1_beats", 32'(cq_dir_cpl_entry.num_beats), 32'd4);
        chk("t1_count", 32'(cq_count),                   32'd1);
        tick();
        @(negedge pclk);
        chk("t1_count0", 32'(cq_count),       32'd0);
        chk("t1_vld0",   32'(cq_dir_cpl_vld), 32'd0);

        // Contention right after a reset: expected order 1,5,2,6
        tick();
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        ri = 0;
        wi = 0;
        for (int c = 0; c < 4; c++) begin
            rd_cq_vld = (ri < 2);
            wr_cq_vld = (wi < 2);
            if (ri < 2) rd_cq_entry = mk(rtags[ri]);
            if (wi < 2) wr_cq_entry = mk(wtags[wi]);
            @(negedge pclk);
            chk("t2_rd_rdy", 32'(rd_cq_rdy), 32'(wins[c] == 0));
            chk("t2_wr_rdy", 32'(wr_cq_rdy), 32'(wins[c] == 1));
            if (wins[c] == 0) begin
                sb.push_back(rd_cq_entry);
                ri++;
            end else begin
                sb.push_back(wr_cq_entry);
                wi++;
            end
            tick();
        end
        rd_cq_vld = 1'b0;
        wr_cq_vld = 1'b0;
        repeat (3) tick();
        @(negedge pclk);
        chk("t2_count", 32'(cq_count),  32'd0);
        chk("t2_sb",    32'(sb.size()), 32'd0);

        // Fill to full with the directory stalled, then free one slot
        tick();
        cq_dir_cpl_rdy = 1'b0;
        rd_cq_vld      = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rd_cq_entry = mk(t);
            @(negedge pclk);
            chk("t3_fill_rdy", 32'(rd_cq_rdy), 32'd1);
            sb.push_back(rd_cq_entry);
            tick();
        end
        rd_cq_entry = mk(4);
        repeat (2) begin
            @(negedge pclk);
            chk("t3_full_rdy", 32'(rd_cq_rdy), 32'd0);
            chk("t3_full_cnt", 32'(cq_count),  32'd4);
            tick();
        end
        cq_dir_cpl_rdy = 1'b1;
        @(negedge pclk);
        chk("t3_no_bypass", 32'(rd_cq_rdy), 32'd0);
        tick();
        cq_dir_cpl_rdy = 1'b0;
        @(negedge pclk);
        chk("t3_cnt3",      32'(cq_count),  32'd3);
        chk("t3_rdy_after", 32'(rd_cq_rdy), 32'd1);
        sb.push_back(rd_cq_entry);
        tick();
        rd_cq_vld = 1'b0;
        @(negedge pclk);
        chk("t3_cnt4", 32'(cq_count), 32'd4);
        tick();
        cq_dir_cpl_rdy = 1'b1;
        repeat (5) tick();
        @(negedge pclk);
        chk("t3_drain", 32'(cq_count),  32'd0);
        chk("t3_sb",    32'(sb.size()), 32'd0);

        // Wrap: ten pushes with continuous pop
        tick();
        rd_cq_vld = 1'b1;
        for (int t = 0; t < 10; t++) begin
            rd_cq_entry = mk(t, t + 1);
            @(negedge pclk);
            chk("t4_rdy", 32'(rd_cq_rdy),        32'd1);
            chk("t4_cnt", 32'(cq_count <= 3'd1), 32'd1);
            sb.push_back(rd_cq_entry);
            tick();
        end
        rd_cq_vld = 1'b0;
        repeat (2) tick();
        @(negedge pclk);
        chk("t4_drain", 32'(cq_count),  32'd0);
        chk("t4_sb",    32'(sb.size()), 32'd0);

        // Backpressure hold of an error completion
        tick();
        cq_dir_cpl_rdy = 1'b0;
        rd_cq_vld      = 1'b1;
        rd_cq_entry    = mk(7, 4, 1, 2);
        e5             = rd_cq_entry;
        @(negedge pclk);
        sb.push_back(rd_cq_entry);
        tick();
        rd_cq_vld   = 1'b0;
        rd_cq_entry = mk(15, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            chk("t5_hold", 32'(cq_dir_cpl_entry), 32'(e5));
            chk("t5_vld",  32'(cq_dir_cpl_vld),   32'd1);
            tick();
        end
        cq_dir_cpl_rdy = 1'b1;
        tick();
        @(negedge pclk);
        chk("t5_vld0", 32'(cq_dir_cpl_vld), 32'd0);
        chk("t5_cnt0", 32'(cq_count),       32'd0);

        // Reset mid-stream discards queued completions
        tick();
        cq_dir_cpl_rdy = 1'b0;
        rd_cq_vld      = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rd_cq_entry = mk(10 + t);
            @(negedge pclk);
            sb.push_back(rd_cq_entry);
            tick();
        end
        rd_cq_vld = 1'b0;
        @(negedge pclk);
        chk("t6_cnt3", 32'(cq_count), 32'd3);
        tick();
        presetn = 1'b0;
        #1;
        chk("t6_rst_vld",   32'(cq_dir_cpl_vld),   32'd0);
        chk("t6_rst_cnt",   32'(cq_count),         32'd0);
        chk("t6_rst_entry", 32'(cq_dir_cpl_entry), 32'd0);
        sb.delete();
        tick();
        presetn        = 1'b1;
        rd_cq_vld      = 1'b1;
        rd_cq_entry    = mk(9);
        cq_dir_cpl_rdy = 1'b1;
        @(negedge pclk);
        chk("t6_first_rdy", 32'(rd_cq_rdy), 32'd1);
        sb.push_back(rd_cq_entry);
        tick();
        rd_cq_vld = 1'b0;
        @(negedge pclk);
        chk("t6_vld", 32'(cq_dir_cpl_vld),       32'd1);
        chk("t6_tag", 32'(cq_dir_cpl_entry.tag), 32'd9);
        tick();
        @(negedge pclk);
        chk("t6_vld0", 32'(cq_dir_cpl_vld), 32'd0);
        chk("t6_cnt0", 32'(cq_count),       32'd0);
        chk("t6_sb",   32'(sb.size()),      32'd0);

        chk("pop_total", 32'(pops), 32'd22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
